// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - shared types, opcode constants and the instruction decoder
// for the decode stage.
package id_stage_pipe_pkg;

   localparam int ID_XLEN          = 32;
   localparam int ID_DEPTH_DEFAULT = 4;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_e;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
   } fmt_e;

   typedef struct packed {
      logic [ID_XLEN-1:0] instr;
      logic [ID_XLEN-1:0] pc;
   } id_entry_t;

   typedef struct packed {
      logic [ID_XLEN-1:0] pc;
      logic [ID_XLEN-1:0] instr;
      logic [ID_XLEN-1:0] imm;
      logic [4:0]         rd;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [2:0]         funct3;
      alu_op_e            alu_op;
      fmt_e               fmt;
      logic               use_imm;
      logic               writes_rd;
      logic               is_load;
      logic               is_store;
      logic               is_branch;
      logic               is_jump;
      logic               illegal;
   } pipeline_bus_t;

   // Immediate forms never encode SUB; bit 30 there is part of the immediate.
   function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic b30, input logic is_imm);
      alu_op_e op;
      op = ALU_ADD;
      case (f3)
         3'b000: op = (b30 && !is_imm) ? ALU_SUB : ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: op = b30 ? ALU_SRA : ALU_SRL;
         3'b110: op = ALU_OR;
         3'b111: op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic pipeline_bus_t decode(input id_entry_t e);
      pipeline_bus_t      b;
      logic [ID_XLEN-1:0] i;
      i        = e.instr;
      b        = '0;
      b.pc     = e.pc;
      b.instr  = i;
      b.rd     = i[11:7];
      b.rs1    = i[19:15];
      b.rs2    = i[24:20];
      b.funct3 = i[14:12];
      b.alu_op = ALU_ADD;
      b.fmt    = FMT_BAD;
      case (i[6:0])
         OPC_OP_IMM: begin
            b.fmt       = FMT_I;
            b.imm       = {{20{i[31]}}, i[31:20]};
            b.use_imm   = 1'b1;
            b.writes_rd = 1'b1;
            b.alu_op    = alu_sel(i[14:12], i[30], 1'b1);
         end
         OPC_OP: begin
            b.fmt       = FMT_R;
            b.writes_rd = 1'b1;
            b.alu_op    = alu_sel(i[14:12], i[30], 1'b0);
         end
         OPC_LUI: begin
            b.fmt       = FMT_U;
            b.imm       = {i[31:12], 12'b0};
            b.use_imm   = 1'b1;
            b.writes_rd = 1'b1;
            b.alu_op    = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            b.fmt       = FMT_U;
            b.imm       = {i[31:12], 12'b0};
            b.use_imm   = 1'b1;
            b.writes_rd = 1'b1;
         end
         OPC_JAL: begin
            b.fmt       = FMT_J;
            b.imm       = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            b.writes_rd = 1'b1;
            b.is_jump   = 1'b1;
         end
         OPC_JALR: begin
            b.fmt       = FMT_I;
            b.imm       = {{20{i[31]}}, i[31:20]};
            b.use_imm   = 1'b1;
            b.writes_rd = 1'b1;
            b.is_jump   = 1'b1;
         end
         OPC_BRANCH: begin
            b.fmt       = FMT_B;
            b.imm       = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            b.is_branch = 1'b1;
            b.alu_op    = ALU_SUB;
         end
         OPC_LOAD: begin
            b.fmt       = FMT_I;
            b.imm       = {{20{i[31]}}, i[31:20]};
            b.use_imm   = 1'b1;
            b.writes_rd = 1'b1;
            b.is_load   = 1'b1;
         end
         OPC_STORE: begin
            b.fmt       = FMT_S;
            b.imm       = {{20{i[31]}}, i[31:25], i[11:7]};
            b.use_imm   = 1'b1;
            b.is_store  = 1'b1;
         end
         default: b.illegal = 1'b1;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/id_stage_pipe_ibuf.sv
// rtl/id_stage_pipe_ibuf.sv - circular FIFO of fetched {instr, pc} entries feeding decode;
// pointers wrap naturally because DEPTH is a power of two.
module id_ibuf
   import id_stage_pipe_pkg::*;
#(
   parameter int DEPTH = ID_DEPTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  id_entry_t                    data,
   output id_entry_t                    head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   id_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries behind a valid count are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage: input queue, decoder and registered output slot.
// Optional ID_BYPASS_EN decodes the input straight into an empty slot when the queue is empty.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int DEPTH = ID_DEPTH_DEFAULT,
   parameter int XLEN  = ID_XLEN
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         if_valid_i,
   output logic                         if_ready_o,
   input  logic [XLEN-1:0]              instruction_i,
   input  logic [XLEN-1:0]              pc_i,
   input  logic                         flush_i,
   output logic                         id_valid_o,
   input  logic                         ex_ready_i,
   output pipeline_bus_t                id_bus_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

   localparam int CW = $clog2(DEPTH+1);

   id_entry_t      in_entry;
   id_entry_t      head;
   id_entry_t      src;
   pipeline_bus_t  decoded;
   logic [CW-1:0]  count;
   logic           empty;
   logic           load_en;
   logic           bypass;
   logic           push;
   logic           pop;

   assign in_entry.instr = instruction_i;
   assign in_entry.pc    = pc_i;

   assign empty       = (count == '0);
   assign occupancy_o = count;
   assign if_ready_o  = rst && !flush_i && (count < CW'(DEPTH));
   assign load_en     = !id_valid_o || ex_ready_i;

`ifdef ID_BYPASS_EN
   assign bypass = empty && load_en && if_valid_i && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed instruction goes straight to the slot and must not also be queued.
   assign push = if_valid_i && if_ready_o && !bypass;
   assign pop  = load_en && !empty && !flush_i;
   assign src  = bypass ? in_entry : head;

   assign decoded = decode(src);

   id_ibuf #(.DEPTH(DEPTH)) u_ibuf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush_i),
      .data  (in_entry),
      .head  (head),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid_o <= 1'b0;
         id_bus_o   <= '0;
      end else if (flush_i) begin
         id_valid_o <= 1'b0;
      end else if (load_en) begin
         if (bypass || !empty) begin
            id_valid_o <= 1'b1;
            id_bus_o   <= decoded;
         end else begin
            id_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed scoreboard bench for id_stage_pipe.
module tb_id_stage_pipe;
   import id_stage_pipe_pkg::*;

`ifdef ID_BYPASS_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = 2;
`endif

   logic          clk;
   logic          rst;
   logic          if_valid_i;
   logic          if_ready_o;
   logic [31:0]   instruction_i;
   logic [31:0]   pc_i;
   logic          flush_i;
   logic          id_valid_o;
   logic          ex_ready_i;
   pipeline_bus_t id_bus_o;
   logic [2:0]    occupancy_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] imm;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          n_out = 0;
   logic [4:0]  cur_rd;
   logic [31:0] cur_imm;

   id_stage_pipe #(.DEPTH(4), .XLEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_valid_i    (if_valid_i),
      .if_ready_o    (if_ready_o),
      .instruction_i (instruction_i),
      .pc_i          (pc_i),
      .flush_i       (flush_i),
      .id_valid_o    (id_valid_o),
      .ex_ready_i    (ex_ready_i),
      .id_bus_o      (id_bus_o),
      .occupancy_o   (occupancy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic [11:0] imm);
      if_valid_i    = 1'b1;
      pc_i          = pc;
      instruction_i = {imm, 5'd0, 3'd0, rd, 7'h13};
      cur_rd        = rd;
      cur_imm       = {20'd0, imm};
   endtask

   // Consume at the negedge before the edge, then record any accepted input.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (id_valid_o && ex_ready_i) begin
         n_out++;
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("out_pc", id_bus_o.pc, e.pc);
            check("out_instr", id_bus_o.instr, e.instr);
            check("out_rd", 32'(id_bus_o.rd), 32'(e.rd));
            check("out_imm", id_bus_o.imm, e.imm);
         end
      end
      if (if_valid_i && if_ready_o)
         sb.push_back('{pc: pc_i, instr: instruction_i, rd: cur_rd, imm: cur_imm});
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int lat;
      int n0;
      rst           = 1'b0;
      if_valid_i    = 1'b0;
      instruction_i = '0;
      pc_i          = '0;
      flush_i       = 1'b0;
      ex_ready_i    = 1'b0;
      cur_rd        = '0;
      cur_imm       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(id_valid_o), 32'd0);
      check("rst_occ", 32'(occupancy_o), 32'd0);
      check("rst_bus", 32'(|id_bus_o), 32'd0);
      check("rst_ready", 32'(if_ready_o), 32'd0);
      rst = 1'b1;
      #1;
      check("ready_after_rst", 32'(if_ready_o), 32'd1);

      // Single addi x1,x0,5 at pc 0x100
      ex_ready_i    = 1'b1;
      if_valid_i    = 1'b1;
      pc_i          = 32'h100;
      instruction_i = 32'h0050_0093;
      cur_rd        = 5'd1;
      cur_imm       = 32'd5;
      tick();
      if_valid_i = 1'b0;
      lat = 1;
      while (!id_valid_o && lat < 6) begin
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(EXP_LAT));
      check("dec_pc", id_bus_o.pc, 32'h100);
      check("dec_rd", 32'(id_bus_o.rd), 32'd1);
      check("dec_rs1", 32'(id_bus_o.rs1), 32'd0);
      check("dec_imm", id_bus_o.imm, 32'd5);
      check("dec_alu", 32'(id_bus_o.alu_op), 32'(ALU_ADD));
      check("dec_fmt", 32'(id_bus_o.fmt), 32'(FMT_I));
      check("dec_wr", 32'(id_bus_o.writes_rd), 32'd1);
      check("dec_useimm", 32'(id_bus_o.use_imm), 32'd1);
      check("dec_illegal", 32'(id_bus_o.illegal), 32'd0);
      drain(6);

      // Backpressure: 4 queued + 1 in slot
      ex_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(32'h200 + 32'(4*i), 5'(i+2), 12'(16+i));
         tick();
      end
      drive(32'h214, 5'd9, 12'd99);
      check("bp_occ", 32'(occupancy_o), 32'd4);
      check("bp_ready", 32'(if_ready_o), 32'd0);
      check("bp_valid", 32'(id_valid_o), 32'd1);
      check("bp_head_pc", id_bus_o.pc, 32'h200);
      tick();
      check("bp_stall_pc", id_bus_o.pc, 32'h200);
      check("bp_sb_size", 32'(sb.size()), 32'd5);
      if_valid_i = 1'b0;
      ex_ready_i = 1'b1;
      drain(10);
      check("bp_occ_end", 32'(occupancy_o), 32'd0);

      // Stream of 16 with EX always ready
      n0 = n_out;
      for (int i = 0; i < 16; i++) begin
         drive(32'h300 + 32'(4*i), 5'((i % 31) + 1), 12'(i));
         check("stream_ready", 32'(if_ready_o), 32'd1);
         tick();
         if (i >= 1) check("stream_valid", 32'(id_valid_o), 32'd1);
      end
      if_valid_i = 1'b0;
      drain(8);
      check("stream_count", 32'(n_out - n0), 32'd16);

      // Flush with 3 queued and a same-cycle input
      ex_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(32'h400 + 32'(4*i), 5'(i+3), 12'(40+i));
         tick();
      end
      check("fl_occ_pre", 32'(occupancy_o), 32'd3);
      drive(32'h480, 5'd7, 12'd7);
      flush_i = 1'b1;
      #1;
      check("fl_ready", 32'(if_ready_o), 32'd0);
      tick();
      flush_i    = 1'b0;
      if_valid_i = 1'b0;
      check("fl_occ", 32'(occupancy_o), 32'd0);
      check("fl_valid", 32'(id_valid_o), 32'd0);
      sb.delete();
      ex_ready_i = 1'b1;
      repeat (3) tick();
      check("fl_occ_after", 32'(occupancy_o), 32'd0);
      check("fl_valid_after", 32'(id_valid_o), 32'd0);

      // Full queue, then sustained pop+push
      ex_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(32'h500 + 32'(4*i), 5'(i+4), 12'(50+i));
         tick();
      end
      drive(32'h514, 5'd10, 12'd60);
      ex_ready_i = 1'b1;
      check("full_ready", 32'(if_ready_o), 32'd0);
      tick();
      check("full_ready_next", 32'(if_ready_o), 32'd1);
      check("full_occ_next", 32'(occupancy_o), 32'd3);
      for (int j = 0; j < 6; j++) begin
         drive(32'h514 + 32'(4*j), 5'(10+j), 12'(60+j));
         tick();
         check("full_occ_steady", 32'(occupancy_o >= 3'd3 && occupancy_o <= 3'd4), 32'd1);
      end
      if_valid_i = 1'b0;
      drain(10);

      // Reset mid-stream with 2 queued
      ex_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h600 + 32'(4*i), 5'(i+5), 12'(70+i));
         tick();
      end
      if_valid_i = 1'b0;
      check("mr_occ_pre", 32'(occupancy_o), 32'd2);
      rst = 1'b0;
      #1;
      check("mr_valid", 32'(id_valid_o), 32'd0);
      check("mr_occ", 32'(occupancy_o), 32'd0);
      check("mr_bus", 32'(|id_bus_o), 32'd0);
      check("mr_ready", 32'(if_ready_o), 32'd0);
      sb.delete();
      repeat (2) tick();
      rst        = 1'b1;
      ex_ready_i = 1'b1;
      drive(32'h700, 5'd11, 12'd77);
      tick();
      if_valid_i = 1'b0;
      lat = 1;
      while (!id_valid_o && lat < 6) begin
         tick();
         lat++;
      end
      check("mr_latency", 32'(lat), 32'(EXP_LAT));
      check("mr_pc", id_bus_o.pc, 32'h700);
      drain(6);
      check("mr_occ_end", 32'(occupancy_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
